sign_unit_sequencer: RTL and testbench

- Sequences the FPU result-sign path for ADD/SUB/MUL/DIV.
- MUL/DIV and effective-add ops resolve from operand signs alone in one cycle.
- Effective-subtract ops issue a request to the magnitude comparator, wait for its answer and pick the sign; equal magnitudes use the rounding mode.
- Sits between the FPU issue stage and the normalise/pack stage, with valid/ready handshakes on both sides and a watchdog on the comparator.

---
 rtl/sign_unit_sequencer.sv | 140 ++++++++++++++
 tb/tb_sign_unit_sequencer.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sign_unit_sequencer.sv
// Result-sign sequencer for FPU ADD/SUB/MUL/DIV. Effective subtracts consult the
// magnitude comparator under a watchdog; everything else resolves from operand signs.
module sign_unit_sequencer #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 5
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       InValid,
    output logic       InReady,
    input  logic [1:0] OpCode,
    input  logic       SignOperandX,
    input  logic       SignOperandY,
    input  logic [1:0] RoundMode,
    output logic       CmpReq,
    input  logic       CmpValid,
    input  logic       CmpXGreater,
    input  logic       CmpEqual,
    output logic       OutValid,
    input  logic       OutReady,
    output logic       ResultSign,
    output logic       EffectiveSub,
    output logic       SignError
);

    typedef enum logic [1:0] {
        StIdle,
        StWaitCmp,
        StOut
    } state_e;

    state_e             state_q, state_d;
    logic               sign_x_q, sign_x_d;
    logic               sign_y_q, sign_y_d;
    logic               op_sub_q, op_sub_d;
    logic [1:0]         rm_q, rm_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               res_sign_q, res_sign_d;
    logic               eff_sub_q, eff_sub_d;
    logic               sign_err_q, sign_err_d;
    logic               in_xor;

    assign in_xor = SignOperandX ^ SignOperandY;

    always_comb begin
        state_d    = state_q;
        sign_x_d   = sign_x_q;
        sign_y_d   = sign_y_q;
        op_sub_d   = op_sub_q;
        rm_d       = rm_q;
        cnt_d      = cnt_q;
        res_sign_d = res_sign_q;
        eff_sub_d  = eff_sub_q;
        sign_err_d = sign_err_q;

        unique case (state_q)
            StIdle: begin
                if (InValid) begin
                    sign_x_d   = SignOperandX;
                    sign_y_d   = SignOperandY;
                    op_sub_d   = OpCode[0];
                    rm_d       = RoundMode;
                    sign_err_d = 1'b0;
                    if (OpCode[1]) begin
                        res_sign_d = in_xor;
                        eff_sub_d  = 1'b0;
                        state_d    = StOut;
                    end else begin
                        eff_sub_d = in_xor ^ OpCode[0];
                        if (in_xor ^ OpCode[0]) begin
                            cnt_d   = '0;
                            state_d = StWaitCmp;
                        end else begin
                            res_sign_d = SignOperandX;
                            state_d    = StOut;
                        end
                    end
                end
            end
            StWaitCmp: begin
                // A comparator answer in the timeout cycle takes priority over the fallback.
                if (CmpValid) begin
                    if (CmpEqual) begin
                        res_sign_d = (rm_q == 2'b10);
                    end else if (CmpXGreater) begin
                        res_sign_d = sign_x_q;
                    end else begin
                        res_sign_d = sign_y_q ^ op_sub_q;
                    end
                    state_d = StOut;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    res_sign_d = sign_x_q;
                    sign_err_d = 1'b1;
                    state_d    = StOut;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StOut: begin
                if (OutReady) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q    <= StIdle;
            sign_x_q   <= 1'b0;
            sign_y_q   <= 1'b0;
            op_sub_q   <= 1'b0;
            rm_q       <= 2'b00;
            cnt_q      <= '0;
            res_sign_q <= 1'b0;
            eff_sub_q  <= 1'b0;
            sign_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sign_x_q   <= sign_x_d;
            sign_y_q   <= sign_y_d;
            op_sub_q   <= op_sub_d;
            rm_q       <= rm_d;
            cnt_q      <= cnt_d;
            res_sign_q <= res_sign_d;
            eff_sub_q  <= eff_sub_d;
            sign_err_q <= sign_err_d;
        end
    end

    // Result fields are masked outside OUT so they read as zero while idle or waiting.
    assign InReady      = (state_q == StIdle) && !Rst;
    assign CmpReq       = (state_q == StWaitCmp);
    assign OutValid     = (state_q == StOut);
    assign ResultSign   = OutValid & res_sign_q;
    assign EffectiveSub = OutValid & eff_sub_q;
    assign SignError    = OutValid & sign_err_q;

endmodule

// File: tb/tb_sign_unit_sequencer.sv
// Scoreboard bench for sign_unit_sequencer: expected signs are queued at accept and
// compared when the result handshake appears.
module tb_sign_unit_sequencer;

    localparam int TIMEOUT = 16;

    logic       Clk = 1'b0;
    logic       Rst = 1'b1;
    logic       InValid = 1'b0;
    logic       InReady;
    logic [1:0] OpCode = 2'b00;
    logic       SignOperandX = 1'b0;
    logic       SignOperandY = 1'b0;
    logic [1:0] RoundMode = 2'b00;
    logic       CmpReq;
    logic       CmpValid = 1'b0;
    logic       CmpXGreater = 1'b0;
    logic       CmpEqual = 1'b0;
    logic       OutValid;
    logic       OutReady = 1'b0;
    logic       ResultSign;
    logic       EffectiveSub;
    logic       SignError;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic sign;
        logic eff;
        logic err;
    } exp_t;

    exp_t sb[$];

    sign_unit_sequencer #(
        .TIMEOUT(TIMEOUT),
        .CNT_W  (5)
    ) dut (
        .Clk         (Clk),
        .Rst         (Rst),
        .InValid     (InValid),
        .InReady     (InReady),
        .OpCode      (OpCode),
        .SignOperandX(SignOperandX),
        .SignOperandY(SignOperandY),
        .RoundMode   (RoundMode),
        .CmpReq      (CmpReq),
        .CmpValid    (CmpValid),
        .CmpXGreater (CmpXGreater),
        .CmpEqual    (CmpEqual),
        .OutValid    (OutValid),
        .OutReady    (OutReady),
        .ResultSign  (ResultSign),
        .EffectiveSub(EffectiveSub),
        .SignError   (SignError)
    );

    always #5 Clk = ~Clk;

    function automatic exp_t model(input logic [1:0] op, input logic x, input logic y,
                                   input logic [1:0] rm, input logic got_cmp,
                                   input logic xg, input logic eq);
        exp_t e;
        logic xr;
        xr    = x ^ y;
        e.err = 1'b0;
        e.eff = op[1] ? 1'b0 : (xr ^ op[0]);
        if (op[1])         e.sign = xr;
        else if (!e.eff)   e.sign = x;
        else if (!got_cmp) begin e.sign = x; e.err = 1'b1; end
        else if (eq)       e.sign = (rm == 2'b10);
        else if (xg)       e.sign = x;
        else               e.sign = y ^ op[0];
        return e;
    endfunction

    // cmp_delay: WAIT_CMP cycle on which CmpValid is offered (0 = never).
    task automatic run_op(input string name, input logic [1:0] op, input logic x,
                          input logic y, input logic [1:0] rm, input int cmp_delay,
                          input logic xg, input logic eq, input int hold);
        exp_t e;
        exp_t got;
        logic needs_cmp;
        int   n;
        int   want_wait;
        needs_cmp = !op[1] && (x ^ y ^ op[0]);
        @(negedge Clk);
        checks++;
        if (InReady !== 1'b1) begin
            failures++;
            $display("FAIL %s in_ready_before: got %b want 1", name, InReady);
        end
        InValid = 1'b1; OpCode = op; SignOperandX = x; SignOperandY = y; RoundMode = rm;
        OutReady = 1'b0;
        sb.push_back(model(op, x, y, rm, cmp_delay > 0, xg, eq));
        @(negedge Clk);
        InValid = 1'b0;
        n = 0;
        if (needs_cmp) begin
            want_wait = (cmp_delay > 0) ? cmp_delay : TIMEOUT;
            while (!OutValid && n < 40) begin
                n++;
                checks++;
                if (CmpReq !== 1'b1) begin
                    failures++;
                    $display("FAIL %s cmp_req_wait%0d: got %b want 1", name, n, CmpReq);
                end
                if (n == cmp_delay) begin
                    CmpValid = 1'b1; CmpXGreater = xg; CmpEqual = eq;
                end
                @(negedge Clk);
                CmpValid = 1'b0; CmpXGreater = 1'b0; CmpEqual = 1'b0;
            end
            checks++;
            if (n !== want_wait) begin
                failures++;
                $display("FAIL %s wait_cycles: got %0d want %0d", name, n, want_wait);
            end
        end else begin
            checks++;
            if (OutValid !== 1'b1 || CmpReq !== 1'b0) begin
                failures++;
                $display("FAIL %s fast_latency: out_valid=%b cmp_req=%b want 1/0",
                         name, OutValid, CmpReq);
            end
        end
        if (!OutValid) begin
            checks++;
            failures++;
            $display("FAIL %s no_out_valid: got 0 want 1", name);
            void'(sb.pop_front());
            return;
        end
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s scoreboard_empty: got 0 entries want 1", name);
            return;
        end
        e = sb.pop_front();
        got = '{sign: ResultSign, eff: EffectiveSub, err: SignError};
        checks++;
        if (got !== e) begin
            failures++;
            $display("FAIL %s result: got sign=%b eff=%b err=%b want sign=%b eff=%b err=%b",
                     name, got.sign, got.eff, got.err, e.sign, e.eff, e.err);
        end
        // Offer a competing MUL during backpressure; it must not be taken.
        for (int i = 0; i < hold; i++) begin
            InValid = 1'b1; OpCode = 2'b10; SignOperandX = ~x; SignOperandY = y;
            @(negedge Clk);
            got = '{sign: ResultSign, eff: EffectiveSub, err: SignError};
            checks++;
            if (OutValid !== 1'b1 || InReady !== 1'b0 || got !== e) begin
                failures++;
                $display("FAIL %s hold%0d: valid=%b ready=%b sign=%b eff=%b err=%b want 1 0 %b %b %b",
                         name, i, OutValid, InReady, got.sign, got.eff, got.err,
                         e.sign, e.eff, e.err);
            end
        end
        InValid = 1'b0;
        OutReady = 1'b1;
        @(negedge Clk);
        OutReady = 1'b0;
        checks++;
        if (OutValid !== 1'b0 || ResultSign !== 1'b0 || EffectiveSub !== 1'b0 ||
            SignError !== 1'b0 || InReady !== 1'b1 || CmpReq !== 1'b0) begin
            failures++;
            $display("FAIL %s back_to_idle: valid=%b sign=%b eff=%b err=%b ready=%b req=%b want 0 0 0 0 1 0",
                     name, OutValid, ResultSign, EffectiveSub, SignError, InReady, CmpReq);
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (InReady !== 1'b0 || OutValid !== 1'b0 || CmpReq !== 1'b0 || ResultSign !== 1'b0 ||
            EffectiveSub !== 1'b0 || SignError !== 1'b0) begin
            failures++;
            $display("FAIL reset_hold: ready=%b valid=%b req=%b sign=%b eff=%b err=%b want all 0",
                     InReady, OutValid, CmpReq, ResultSign, EffectiveSub, SignError);
        end
        @(negedge Clk);
        @(negedge Clk);
        Rst = 1'b0;
        #1;
        checks++;
        if (InReady !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_ready: got %b want 1", InReady);
        end
    endtask

    task automatic test_fast_path();
        run_op("mul_x1_y0", 2'b10, 1'b1, 1'b0, 2'b00, 0, 1'b0, 1'b0, 0);
        run_op("div_x1_y1", 2'b11, 1'b1, 1'b1, 2'b11, 0, 1'b0, 1'b0, 0);
        run_op("add_x1_y1", 2'b00, 1'b1, 1'b1, 2'b00, 0, 1'b0, 1'b0, 0);
        run_op("sub_x0_y1", 2'b01, 1'b0, 1'b1, 2'b00, 0, 1'b0, 1'b0, 0);
    endtask

    task automatic test_compare();
        run_op("sub_y_bigger", 2'b01, 1'b0, 1'b0, 2'b00, 3, 1'b0, 1'b0, 0);
        run_op("sub_x_bigger", 2'b01, 1'b0, 1'b0, 2'b00, 3, 1'b1, 1'b0, 0);
        run_op("add_y_bigger", 2'b00, 1'b1, 1'b0, 2'b00, 1, 1'b0, 1'b0, 0);
        run_op("add_eq_rdn", 2'b00, 1'b0, 1'b1, 2'b10, 2, 1'b0, 1'b1, 0);
        run_op("add_eq_rne", 2'b00, 1'b0, 1'b1, 2'b00, 2, 1'b1, 1'b1, 0);
        run_op("sub_eq_rup", 2'b01, 1'b1, 1'b1, 2'b11, 4, 1'b0, 1'b1, 0);
    endtask

    task automatic test_timeout();
        run_op("timeout_x1", 2'b01, 1'b1, 1'b1, 2'b00, 0, 1'b0, 1'b0, 0);
        run_op("timeout_x0", 2'b00, 1'b0, 1'b1, 2'b10, 0, 1'b0, 1'b0, 0);
        run_op("cmp_on_last", 2'b01, 1'b1, 1'b1, 2'b00, TIMEOUT, 1'b0, 1'b0, 0);
    endtask

    task automatic test_backpressure();
        run_op("bp_mul", 2'b10, 1'b0, 1'b1, 2'b00, 0, 1'b0, 1'b0, 5);
        run_op("bp_sub", 2'b01, 1'b1, 1'b1, 2'b00, 2, 1'b1, 1'b0, 5);
    endtask

    task automatic test_reset_mid_wait();
        @(negedge Clk);
        InValid = 1'b1; OpCode = 2'b01; SignOperandX = 1'b0; SignOperandY = 1'b0;
        @(negedge Clk);
        InValid = 1'b0;
        @(negedge Clk);
        checks++;
        if (CmpReq !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid_wait_entry: cmp_req got %b want 1", CmpReq);
        end
        Rst = 1'b1;
        #1;
        checks++;
        if (CmpReq !== 1'b0 || OutValid !== 1'b0 || InReady !== 1'b0 ||
            ResultSign !== 1'b0 || EffectiveSub !== 1'b0 || SignError !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_wait_outputs: req=%b valid=%b ready=%b sign=%b eff=%b err=%b want all 0",
                     CmpReq, OutValid, InReady, ResultSign, EffectiveSub, SignError);
        end
        @(negedge Clk);
        Rst = 1'b0;
        #1;
        checks++;
        if (InReady !== 1'b1 || CmpReq !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_wait_release: ready=%b req=%b want 1 0", InReady, CmpReq);
        end
        run_op("after_reset", 2'b00, 1'b1, 1'b0, 2'b00, 2, 1'b0, 1'b0, 0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            logic [1:0] op;
            logic       x;
            logic       y;
            logic [1:0] rm;
            op = 2'($urandom_range(0, 3));
            x  = 1'($urandom_range(0, 1));
            y  = 1'($urandom_range(0, 1));
            rm = 2'($urandom_range(0, 3));
            run_op("rand_op", op, x, y, rm, int'($urandom_range(1, 5)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), i % 2);
        end
    endtask

    initial begin
        test_reset();
        test_fast_path();
        test_compare();
        test_timeout();
        test_backpressure();
        test_reset_mid_wait();
        test_back_to_back();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d entries want 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
